demux1by2_8bit_stream: RTL and testbench
========================================

DEMUX1BY2_8BIT_STREAM -- requirements
Module: demux1by2_8bit_stream

Interface
REQ-001 Parameter: CNT_W, default 8, width of each per-port packet counter.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 in_data  input  8  input byte.
REQ-005 in_valid  input  1  in_data/in_last/in_sel valid.
REQ-006 in_last  input  1  current beat ends the packet.
REQ-007 in_sel  input  1  destination, sampled on first beat of packet only; 0 -> port 0, 1 -> port 1.
REQ-008 in_ready  output  1  block accepts the current beat.
REQ-009 out0_data / out1_data  output  8  routed byte per port.
REQ-010 out0_valid / out1_valid  output  1  port holds a byte.
REQ-011 out0_last / out1_last  output  1  held byte ends a packet.
REQ-012 out0_ready / out1_ready  input  1  downstream accepts the port's byte.
REQ-013 pkt_cnt0 / pkt_cnt1  output  CNT_W  packets routed per port.
REQ-014 busy  output  1  packet open or any port valid.

Function
REQ-015 Input transfer SHALL occur on a rising edge with in_valid=1 and in_ready=1; output transfer k on outk_valid=1 and outk_ready=1.
REQ-016 FSM states ST_IDLE, ST_LOCK0, ST_LOCK1; target port = in_sel in ST_IDLE, k in ST_LOCKk.
REQ-017 ST_IDLE: accepted beat with in_last=0 -> ST_LOCK[in_sel]; accepted beat with in_last=1 -> stay ST_IDLE (single-beat packet).
REQ-018 ST_LOCKk: in_sel ignored; accepted beat with in_last=1 -> ST_IDLE; otherwise hold.
REQ-019 in_valid may drop mid-packet; lock SHALL persist until the in_last beat is accepted.
REQ-020 Each port has a one-entry output register; in_ready = target register empty OR target outk_ready=1 (same-cycle drain-and-refill allowed, full throughput).
REQ-021 Latency: beat accepted at edge N SHALL appear on outk_* with outk_valid=1 from edge N onward (one cycle after presentation).
REQ-022 While outk_valid=1 and outk_ready=0, outk_data and outk_last SHALL remain stable.
REQ-023 Non-target port SHALL drain independently of the input side.
REQ-024 pkt_cntk SHALL increment by 1 when an in_last beat is accepted into port k; wraps 2^CNT_W-1 -> 0.
REQ-025 busy = (state != ST_IDLE) OR out0_valid OR out1_valid.
REQ-026 Routing SHALL never duplicate or reorder bytes; each accepted byte reaches exactly one port.

Reset
REQ-027 rst_n=0 at a rising edge: state -> ST_IDLE, out0_valid=out1_valid=0, out*_data=0, out*_last=0, pkt_cnt0=pkt_cnt1=0.
REQ-028 in_ready SHALL be 0 while rst_n=0; 1 in the first cycle after release (empty buffers).
REQ-029 Reset mid-packet or with buffered bytes SHALL drop in-flight data without emitting it; the next beat after release is treated as a first beat.

Structure
REQ-030 Shared package demux_pkg SHALL hold the state enum typedef (ST_IDLE, ST_LOCK0, ST_LOCK1) and the default CNT_W constant.
REQ-031 One sub-module out_reg_8bit (one-entry byte+last register with valid/ready) SHALL be instantiated twice, once per port.

Verification
REQ-032 Reset, then in_sel=1, in_data=0xA5, in_last=1, one beat -> out1_data=0xA5, out1_last=1 next cycle; out0_valid=0; pkt_cnt1=1.
REQ-033 4-beat packet 0x10..0x13, in_sel=0 on first beat, in_sel toggled on beats 2-4 -> all four bytes on port 0 in order; state ST_LOCK0 until beat 4; pkt_cnt0=1.
REQ-034 out0_ready=0 with port 0 full, new beat targeting port 0 -> in_ready=0, out0_data stable; raise out0_ready -> drain and refill in same cycle.
REQ-035 Port 1 stalled full, packet to port 0 streamed -> port 0 continues at one byte/cycle; port 1 byte unchanged.
REQ-036 Reset asserted mid-packet (beat 2 of 4, port 1 holding byte) -> out1_valid=0, counters 0, ST_IDLE; next beat with in_sel=0 routed to port 0.
REQ-037 256 single-beat packets to port 0 (CNT_W=8) -> pkt_cnt0 wraps to 0; pkt_cnt1 remains 0.

Source files
------------

// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared state encoding and default counter width for the 1:2 byte stream demux
package demux_pkg;

  localparam int DEFAULT_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } state_e;

endpackage

// File: rtl/out_reg_8bit.sv
// rtl/out_reg_8bit.sv - one-entry byte+last register with valid/ready on both sides
module out_reg_8bit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] s_tdata,
  input  logic       s_tlast,
  input  logic       s_tvalid,
  output logic       s_tready,
  output logic [7:0] m_tdata,
  output logic       m_tlast,
  output logic       m_tvalid,
  input  logic       m_tready
);

  logic [7:0] data_q, data_d;
  logic       last_q, last_d;
  logic       valid_q, valid_d;

  // Draining and refilling in the same cycle keeps a full-rate stream flowing.
  assign s_tready = !valid_q || m_tready;

  always_comb begin
    data_d  = data_q;
    last_d  = last_q;
    valid_d = valid_q;
    if (s_tvalid && s_tready) begin
      data_d  = s_tdata;
      last_d  = s_tlast;
      valid_d = 1'b1;
    end else if (m_tready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q  <= 8'd0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  assign m_tdata  = data_q;
  assign m_tlast  = last_q;
  assign m_tvalid = valid_q;

endmodule

// File: rtl/demux1by2_8bit_stream.sv
// rtl/demux1by2_8bit_stream.sv - packet-locked 1:2 byte stream demux with per-port packet counters
module demux1by2_8bit_stream
  import demux_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  input  logic             in_last,
  input  logic             in_sel,
  output logic             in_ready,
  output logic [7:0]       out0_data,
  output logic             out0_valid,
  output logic             out0_last,
  input  logic             out0_ready,
  output logic [7:0]       out1_data,
  output logic             out1_valid,
  output logic             out1_last,
  input  logic             out1_ready,
  output logic [CNT_W-1:0] pkt_cnt0,
  output logic [CNT_W-1:0] pkt_cnt1,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;
  logic             target;
  logic             rdy0, rdy1;
  logic             accept;
  logic             load0, load1;

  // in_sel only matters on the first beat; a locked packet keeps its port.
  always_comb begin
    target = in_sel;
    if (state_q == ST_LOCK0) target = 1'b0;
    else if (state_q == ST_LOCK1) target = 1'b1;
  end

  assign in_ready = rst_n && (target ? rdy1 : rdy0);
  assign accept   = in_valid && in_ready;
  assign load0    = accept && !target;
  assign load1    = accept && target;

  always_comb begin
    state_d = state_q;
    cnt0_d  = cnt0_q;
    cnt1_d  = cnt1_q;
    if (accept) begin
      if (in_last) begin
        state_d = ST_IDLE;
        if (target) cnt1_d = cnt1_q + CNT_W'(1);
        else        cnt0_d = cnt0_q + CNT_W'(1);
      end else if (state_q == ST_IDLE) begin
        state_d = target ? ST_LOCK1 : ST_LOCK0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end

  out_reg_8bit u_out0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_tdata  (in_data),
    .s_tlast  (in_last),
    .s_tvalid (load0),
    .s_tready (rdy0),
    .m_tdata  (out0_data),
    .m_tlast  (out0_last),
    .m_tvalid (out0_valid),
    .m_tready (out0_ready)
  );

  out_reg_8bit u_out1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_tdata  (in_data),
    .s_tlast  (in_last),
    .s_tvalid (load1),
    .s_tready (rdy1),
    .m_tdata  (out1_data),
    .m_tlast  (out1_last),
    .m_tvalid (out1_valid),
    .m_tready (out1_ready)
  );

  assign pkt_cnt0 = cnt0_q;
  assign pkt_cnt1 = cnt1_q;
  assign busy     = (state_q != ST_IDLE) || out0_valid || out1_valid;

endmodule

// File: tb/tb_demux1by2_8bit_stream.sv
// tb/tb_demux1by2_8bit_stream.sv - directed self-checking bench for the 1:2 byte stream demux
module tb_demux1by2_8bit_stream;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid, in_last, in_sel, in_ready;
  logic [7:0] out0_data, out1_data;
  logic       out0_valid, out0_last, out0_ready;
  logic       out1_valid, out1_last, out1_ready;
  logic [7:0] pkt_cnt0, pkt_cnt1;
  logic       busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  demux1by2_8bit_stream #(.CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_sel     (in_sel),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_last  (out0_last),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_last  (out1_last),
    .out1_ready (out1_ready),
    .pkt_cnt0   (pkt_cnt0),
    .pkt_cnt1   (pkt_cnt1),
    .busy       (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic [7:0] d, input logic l);
    in_valid = v;
    in_sel   = s;
    in_data  = d;
    in_last  = l;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 8'hFF, 1'b0);
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    tick();
    tick();
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    total++;
    if ({out0_valid, out1_valid, busy} !== 3'b000) begin
      bad++; $display("FAIL reset_valid_busy got=%b exp=000", {out0_valid, out1_valid, busy});
    end
    total++;
    if ({out0_data, out1_data, out0_last, out1_last} !== 18'd0) begin
      bad++; $display("FAIL reset_data got=%h/%h last=%b%b exp=0", out0_data, out1_data, out0_last, out1_last);
    end
    total++;
    if ({pkt_cnt0, pkt_cnt1} !== 16'd0) begin
      bad++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", pkt_cnt0, pkt_cnt1);
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_single_beat();
    drive(1'b1, 1'b1, 8'hA5, 1'b1);
    tick();
    in_valid = 1'b0;
    total++;
    if ({out1_valid, out1_data, out1_last} !== {1'b1, 8'hA5, 1'b1}) begin
      bad++; $display("FAIL single_out1 got v=%b d=%h l=%b exp v=1 d=a5 l=1", out1_valid, out1_data, out1_last);
    end
    total++;
    if (out0_valid !== 1'b0) begin bad++; $display("FAIL single_out0_idle got=%b exp=0", out0_valid); end
    total++;
    if (pkt_cnt1 !== 8'd1) begin bad++; $display("FAIL single_cnt1 got=%0d exp=1", pkt_cnt1); end
    tick();
    total++;
    if ({out1_valid, busy} !== 2'b00) begin
      bad++; $display("FAIL single_drained got v=%b busy=%b exp 0/0", out1_valid, busy);
    end
  endtask

  task automatic test_lock();
    logic [7:0] exp_d [4] = '{8'h10, 8'h11, 8'h12, 8'h13};
    logic       sels  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, sels[i], exp_d[i], i == 3);
      tick();
      total++;
      if ({out0_valid, out0_data, out0_last, out1_valid} !== {1'b1, exp_d[i], i == 3, 1'b0}) begin
        bad++; $display("FAIL lock_beat%0d got v0=%b d0=%h l0=%b v1=%b exp d0=%h", i, out0_valid, out0_data, out0_last, out1_valid, exp_d[i]);
      end
      if (i == 1) begin
        // gap mid-packet with in_sel pointing at port 1; lock must hold
        drive(1'b0, 1'b1, 8'hEE, 1'b1);
        tick();
        total++;
        if ({out0_valid, out1_valid, busy} !== 3'b001) begin
          bad++; $display("FAIL lock_gap got v0=%b v1=%b busy=%b exp 0/0/1", out0_valid, out1_valid, busy);
        end
      end
    end
    in_valid = 1'b0;
    tick();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL lock_idle_busy got=%b exp=0", busy); end
    total++;
    if (pkt_cnt0 !== 8'd1) begin bad++; $display("FAIL lock_cnt0 got=%0d exp=1", pkt_cnt0); end
  endtask

  task automatic test_backpressure();
    out0_ready = 1'b0;
    drive(1'b1, 1'b0, 8'h55, 1'b1);
    tick();
    drive(1'b1, 1'b0, 8'h66, 1'b1);
    #1;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
    tick();
    total++;
    if ({out0_valid, out0_data} !== {1'b1, 8'h55}) begin
      bad++; $display("FAIL bp_stable got v=%b d=%h exp v=1 d=55", out0_valid, out0_data);
    end
    out0_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    total++;
    if ({out0_valid, out0_data} !== {1'b1, 8'h66}) begin
      bad++; $display("FAIL bp_refill got v=%b d=%h exp v=1 d=66", out0_valid, out0_data);
    end
    tick();
    total++;
    if ({out0_valid, pkt_cnt0} !== {1'b0, 8'd3}) begin
      bad++; $display("FAIL bp_end got v=%b cnt0=%0d exp v=0 cnt0=3", out0_valid, pkt_cnt0);
    end
  endtask

  task automatic test_independent();
    out1_ready = 1'b0;
    drive(1'b1, 1'b1, 8'h77, 1'b1);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 8'h20 + 8'(i), i == 3);
      #1;
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL ind_ready%0d got=%b exp=1", i, in_ready); end
      tick();
      total++;
      if ({out0_valid, out0_data, out1_valid, out1_data} !== {1'b1, 8'h20 + 8'(i), 1'b1, 8'h77}) begin
        bad++; $display("FAIL ind_beat%0d got d0=%h v0=%b d1=%h v1=%b exp d0=%h d1=77", i, out0_data, out0_valid, out1_data, out1_valid, 8'h20 + 8'(i));
      end
    end
    in_valid = 1'b0;
    out1_ready = 1'b1;
    tick();
    total++;
    if ({out0_valid, out1_valid, pkt_cnt0, pkt_cnt1} !== {2'b00, 8'd4, 8'd2}) begin
      bad++; $display("FAIL ind_end got v=%b%b cnt=%0d/%0d exp 00 4/2", out0_valid, out1_valid, pkt_cnt0, pkt_cnt1);
    end
  endtask

  task automatic test_reset_mid_packet();
    out1_ready = 1'b0;
    drive(1'b1, 1'b1, 8'h30, 1'b0);
    tick();
    drive(1'b1, 1'b1, 8'h31, 1'b0);
    rst_n = 1'b0;
    tick();
    in_valid = 1'b0;
    total++;
    if ({out1_valid, busy, pkt_cnt0, pkt_cnt1} !== {2'b00, 8'd0, 8'd0}) begin
      bad++; $display("FAIL rmid_state got v1=%b busy=%b cnt=%0d/%0d exp 0/0 0/0", out1_valid, busy, pkt_cnt0, pkt_cnt1);
    end
    rst_n = 1'b1;
    out0_ready = 1'b1;
    drive(1'b1, 1'b0, 8'h40, 1'b0);
    tick();
    total++;
    if ({out0_valid, out0_data, out1_valid} !== {1'b1, 8'h40, 1'b0}) begin
      bad++; $display("FAIL rmid_first got v0=%b d0=%h v1=%b exp 1/40/0", out0_valid, out0_data, out1_valid);
    end
    drive(1'b1, 1'b1, 8'h41, 1'b1);
    tick();
    in_valid = 1'b0;
    total++;
    if ({out0_data, out1_valid, pkt_cnt0} !== {8'h41, 1'b0, 8'd1}) begin
      bad++; $display("FAIL rmid_locked got d0=%h v1=%b cnt0=%0d exp 41/0/1", out0_data, out1_valid, pkt_cnt0);
    end
    out1_ready = 1'b1;
    tick();
  endtask

  task automatic test_wrap();
    rst_n = 1'b0;
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    out0_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 1'b0, 8'(i), 1'b1);
      tick();
      if (i == 254) begin
        total++;
        if (pkt_cnt0 !== 8'd255) begin bad++; $display("FAIL wrap_255 got=%0d exp=255", pkt_cnt0); end
      end
    end
    in_valid = 1'b0;
    total++;
    if ({pkt_cnt0, pkt_cnt1} !== 16'd0) begin
      bad++; $display("FAIL wrap_zero got=%0d/%0d exp=0/0", pkt_cnt0, pkt_cnt1);
    end
    total++;
    if ({out0_valid, out0_data} !== {1'b1, 8'hFF}) begin
      bad++; $display("FAIL wrap_last_byte got v=%b d=%h exp 1/ff", out0_valid, out0_data);
    end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_lock();
    test_backpressure();
    test_independent();
    test_reset_mid_packet();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
